// File: rtl/lab3_pkg.sv
// Shared types and defaults for the lab 3 countdown response checker.
//   state_t     : checker FSM states
//   LAB3_WIDTH  : default observed vector width ({a..f})
//   LAB3_START  : default start / arming value
package lab3_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArm   = 2'd1,
        StCheck = 2'd2,
        StDone  = 2'd3
    } state_t;

    localparam int unsigned LAB3_WIDTH = 6;
    localparam int unsigned LAB3_START = 63;

endpackage

// File: rtl/lab3_satcnt.sv
// Generic saturating up-counter.
//   clk : clock
//   rst : synchronous active-high reset
//   clr : synchronous clear (wins over inc)
//   inc : increment by one, sticking at all-ones
//   cnt : current count
module lab3_satcnt #(
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [ERR_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + ERR_W'(1);
        end
    end

endmodule

// File: rtl/lab3_check.sv
// Response checker for the lab 3 six-bit countdown pattern.
//   clk, rst            : clock, synchronous active-high reset
//   a..f                : observed vector {a,b,c,d,e,f}, a is the MSB
//   sample              : strobe, vector is stable this cycle
//   start               : arm request (honoured in IDLE and DONE)
//   busy, done, pass    : status; pass only valid while done
//   err_cnt             : saturating mismatch count
//   vec_cnt             : vectors consumed, including the arming vector
//   first_exp/first_got : expected/observed value at the first mismatch
module lab3_check
    import lab3_pkg::*;
#(
    parameter int unsigned WIDTH = LAB3_WIDTH,
    parameter int unsigned START = LAB3_START,
    parameter int unsigned COUNT = 64,
    parameter int unsigned ERR_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         a,
    input  logic                         b,
    input  logic                         c,
    input  logic                         d,
    input  logic                         e,
    input  logic                         f,
    input  logic                         sample,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [ERR_W-1:0]             err_cnt,
    output logic [$clog2(COUNT+1)-1:0]   vec_cnt,
    output logic [WIDTH-1:0]             first_exp,
    output logic [WIDTH-1:0]             first_got
);

    localparam int unsigned VEC_W = $clog2(COUNT + 1);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(COUNT);
    localparam logic [WIDTH-1:0] START_V  = WIDTH'(START);
    localparam logic [WIDTH-1:0] ARMED_V  = WIDTH'(START - 1);

    state_t           state_q;
    logic [WIDTH-1:0] in_q;
    logic             sample_q;
    logic [WIDTH-1:0] exp_q;
    logic             mismatch;
    logic             err_inc;
    logic             err_clr;

    assign mismatch = (in_q != exp_q);
    assign err_inc  = (state_q == StCheck) && sample_q && mismatch;
    assign err_clr  = start && ((state_q == StIdle) || (state_q == StDone));

    lab3_satcnt #(
        .ERR_W (ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (err_clr),
        .inc (err_inc),
        .cnt (err_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            in_q      <= '0;
            sample_q  <= 1'b0;
            exp_q     <= '0;
            vec_cnt   <= '0;
            first_exp <= '0;
            first_got <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            in_q     <= WIDTH'({a, b, c, d, e, f});
            sample_q <= sample;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q   <= StArm;
                        exp_q     <= START_V;
                        vec_cnt   <= '0;
                        first_exp <= '0;
                        first_got <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                StArm: begin
                    // Anything other than the start value is pre-roll noise, not an error.
                    if (sample_q && (in_q == START_V)) begin
                        vec_cnt <= VEC_W'(1);
                        exp_q   <= ARMED_V;
                        if (COUNT == 1) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= 1'b1;
                        end else begin
                            state_q <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (sample_q) begin
                        // err_cnt is still zero exactly until the first mismatch lands.
                        if (mismatch && (err_cnt == '0)) begin
                            first_exp <= exp_q;
                            first_got <= in_q;
                        end
                        exp_q   <= exp_q - WIDTH'(1);
                        vec_cnt <= vec_cnt + VEC_W'(1);
                        if ((vec_cnt + VEC_W'(1)) == VEC_LAST) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            // Look ahead: err_cnt updates on this same edge.
                            pass    <= (err_cnt == '0) && !mismatch;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lab3_check.sv
module tb_lab3_check;

    logic       clk = 1'b0;
    logic       rst_s = 1'b1;
    logic       start_s = 1'b0;
    logic       sample_s = 1'b0;
    logic [5:0] vec = 6'd0;

    logic       busy, done, pass;
    logic [7:0] err_cnt;
    logic [6:0] vec_cnt;
    logic [5:0] first_exp, first_got;
    logic       busy2, done2, pass2;
    logic [1:0] err_cnt2;
    logic [6:0] vec_cnt2;
    logic [5:0] first_exp2, first_got2;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    lab3_check #(.WIDTH(6), .START(63), .COUNT(64), .ERR_W(8)) u_dut (
        .clk(clk), .rst(rst_s),
        .a(vec[5]), .b(vec[4]), .c(vec[3]), .d(vec[2]), .e(vec[1]), .f(vec[0]),
        .sample(sample_s), .start(start_s),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .vec_cnt(vec_cnt),
        .first_exp(first_exp), .first_got(first_got)
    );

    lab3_check #(.WIDTH(6), .START(63), .COUNT(64), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst(rst_s),
        .a(vec[5]), .b(vec[4]), .c(vec[3]), .d(vec[2]), .e(vec[1]), .f(vec[0]),
        .sample(sample_s), .start(start_s),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2), .vec_cnt(vec_cnt2),
        .first_exp(first_exp2), .first_got(first_got2)
    );

    // Reference model: mode 0 idle, 1 waiting for 63, 2 counting down, 3 finished.
    // The expected value is derived from how many vectors have been consumed.
    int         m_mode = 0;
    int         m_n    = 0;
    int         m_errs = 0;
    int         m_fe   = 0;
    int         m_fg   = 0;
    int         m_pin  = 0;
    bit         m_ps   = 1'b0;

    always @(posedge clk) begin
        int pin;
        bit ps;
        int want;
        if (rst_s) begin
            m_mode = 0; m_n = 0; m_errs = 0; m_fe = 0; m_fg = 0; m_pin = 0; m_ps = 1'b0;
        end else begin
            pin = m_pin;
            ps  = m_ps;
            m_pin = int'(vec);
            m_ps  = sample_s;
            if ((m_mode == 0 || m_mode == 3) && start_s) begin
                m_mode = 1; m_n = 0; m_errs = 0; m_fe = 0; m_fg = 0;
            end else if (m_mode == 1 && ps && pin == 63) begin
                m_n = 1;
                m_mode = 2;
            end else if (m_mode == 2 && ps) begin
                want = (63 - m_n) & 63;
                if (pin != want) begin
                    if (m_errs == 0) begin
                        m_fe = want;
                        m_fg = pin;
                    end
                    m_errs++;
                end
                m_n++;
                if (m_n == 64) m_mode = 3;
            end
        end
    end

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",       32'(busy),       32'(m_mode == 1 || m_mode == 2));
            chk("done",       32'(done),       32'(m_mode == 3));
            chk("pass",       32'(pass),       32'(m_mode == 3 && m_errs == 0));
            chk("err_cnt",    32'(err_cnt),    32'(sat(m_errs, 255)));
            chk("vec_cnt",    32'(vec_cnt),    32'(m_n));
            chk("first_exp",  32'(first_exp),  32'(m_fe));
            chk("first_got",  32'(first_got),  32'(m_fg));
            chk("busy2",      32'(busy2),      32'(m_mode == 1 || m_mode == 2));
            chk("done2",      32'(done2),      32'(m_mode == 3));
            chk("pass2",      32'(pass2),      32'(m_mode == 3 && m_errs == 0));
            chk("err_cnt2",   32'(err_cnt2),   32'(sat(m_errs, 3)));
            chk("vec_cnt2",   32'(vec_cnt2),   32'(m_n));
            chk("first_exp2", 32'(first_exp2), 32'(m_fe));
            chk("first_got2", 32'(first_got2), 32'(m_fg));
        end
    end

    // Apply inputs for one clock, returning at the next falling edge.
    task automatic drive(input logic r, input logic st, input logic sm, input logic [5:0] v);
        rst_s = r; start_s = st; sample_s = sm; vec = v;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 6'($urandom));
    endtask

    // One sampled vector followed by gap-1 noise cycles.
    task automatic send(input logic [5:0] v, input int gap, input logic st);
        drive(1'b0, st, 1'b1, v);
        idle(gap - 1);
    endtask

    task automatic arm();
        drive(1'b0, 1'b1, 1'b0, 6'd0);
    endtask

    task automatic countdown(input int gap, input int bad_at, input int bad_val,
                             input int start_at);
        for (int v = 63; v >= 0; v--) begin
            send((v == bad_at) ? 6'(bad_val) : 6'(v), gap, v == start_at);
        end
        idle(3);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 6'd0);
        cmp_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err",  32'(err_cnt), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 6'd0);

        // Clean run, sample every 4 clocks.
        arm();
        countdown(4, -1, 0, -1);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_err",  32'(err_cnt), 32'd0);
        chk("t1_vec",  32'(vec_cnt), 32'd64);

        // Vector 41 replaced by 40.
        arm();
        countdown(4, 41, 40, -1);
        chk("t2_err", 32'(err_cnt), 32'd1);
        chk("t2_fe",  32'(first_exp), 32'd41);
        chk("t2_fg",  32'(first_got), 32'd40);
        chk("t2_pass", 32'(pass), 32'd0);

        // Pre-arm noise samples are discarded.
        arm();
        send(6'd10, 2, 1'b0);
        send(6'd5, 2, 1'b0);
        countdown(2, -1, 0, -1);
        chk("t3_err",  32'(err_cnt), 32'd0);
        chk("t3_pass", 32'(pass), 32'd1);

        // Reset mid-run with a concurrent start.
        arm();
        for (int v = 63; v > 43; v--) send(6'(v), 4, 1'b0);
        chk("t4_vec20", 32'(vec_cnt), 32'd20);
        drive(1'b1, 1'b1, 1'b0, 6'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_vec",  32'(vec_cnt), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        arm();
        countdown(1, -1, 0, -1);
        chk("t4_pass", 32'(pass), 32'd1);

        // Saturation: arm with 63, then 63 held for 63 more samples.
        arm();
        for (int i = 0; i < 64; i++) send(6'd63, 1, 1'b0);
        idle(3);
        chk("t5_err2", 32'(err_cnt2), 32'd3);
        chk("t5_err8", 32'(err_cnt), 32'd63);
        chk("t5_fe",   32'(first_exp2), 32'd62);
        chk("t5_fg",   32'(first_got2), 32'd63);
        chk("t5_done", 32'(done2), 32'd1);
        chk("t5_pass", 32'(pass2), 32'd0);

        // Start during CHECK ignored; start in DONE re-arms.
        arm();
        countdown(3, -1, 0, 30);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_pass", 32'(pass), 32'd1);
        arm();
        chk("t6_rearm_done", 32'(done), 32'd0);
        chk("t6_rearm_busy", 32'(busy), 32'd1);
        chk("t6_rearm_vec",  32'(vec_cnt), 32'd0);
        chk("t6_rearm_err",  32'(err_cnt), 32'd0);

        // Randomized traffic, mostly-correct countdowns with occasional errors/resets.
        for (int i = 0; i < 5000; i++) begin
            int   r;
            int   nxt;
            logic sm;
            logic [5:0] v;
            r   = int'($urandom_range(0, 999));
            sm  = ($urandom_range(0, 2) != 0);
            nxt = m_n + ((m_mode == 2 && m_ps) ? 1 : 0);
            if (m_mode == 1) v = ($urandom_range(0, 9) < 7) ? 6'd63 : 6'($urandom);
            else if (m_mode == 2) v = ($urandom_range(0, 99) < 93) ? 6'((63 - nxt) & 63)
                                                                   : 6'($urandom);
            else v = 6'($urandom);
            drive(r < 3, r < 20, sm, v);
        end
        idle(4);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
